// File: rtl/spi_master_pkg.sv
// Shared register addresses, FSM state encoding and control-bit positions for spi_master_gen.
package spi_master_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_FF     = 3'd1;
    localparam logic [2:0] ADDR_00     = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_CS     = 3'd4;
    localparam logic [2:0] ADDR_DIV    = 3'd5;
    localparam logic [2:0] ADDR_IRQCLR = 3'd6;
    localparam logic [2:0] ADDR_INIT   = 3'd7;

    localparam logic [2:0] ADDR_RX     = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam int CTRL_CPOL   = 0;
    localparam int CTRL_CPHA   = 1;
    localparam int CTRL_LSB    = 2;
    localparam int CTRL_IRQ_EN = 3;

    // Advance the transmit shift register by one bit in the selected order.
    function automatic logic [7:0] shift_tx(input logic [7:0] v, input logic lsb_first);
        return lsb_first ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses tick for one cycle every div+1 enabled cycles.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && !clr && (cnt_q == div);
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// Bus-mapped SPI master: programmable divider, CPOL/CPHA, bit order, one-hot CS, SD-style init burst.
// Define SPI_IRQ_EN to build the transfer-complete interrupt (ctrl bit3, W6, status bit6).
module spi_master_gen
    import spi_master_pkg::*;
#(
    parameter int NUM_CS      = 2,
    parameter int DIV_W       = 8,
    parameter int INIT_DIV    = 63,
    parameter int INIT_CLOCKS = 80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              rnw,
    input  logic [2:0]        addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic [NUM_CS-1:0] ss,
    output logic              irq
);
    localparam int INIT_TICKS = 2 * INIT_CLOCKS;
    localparam int TCW = ($clog2(INIT_TICKS) > 4) ? $clog2(INIT_TICKS) : 4;
    localparam logic [DIV_W-1:0] INIT_DIV_V = DIV_W'(INIT_DIV);
    localparam logic [TCW-1:0]   INIT_LAST  = TCW'(INIT_TICKS - 1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [NUM_CS-1:0] cs_mask_q, cs_mask_d, ss_q, ss_d;
    logic [7:0]        tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_q, rx_d, dout_q, dout_d;
    logic [TCW-1:0]    edge_cnt_q, edge_cnt_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d;
    logic              irq_flag;
`ifdef SPI_IRQ_EN
    logic              irq_q, irq_d, irq_en_q, irq_en_d;
    assign irq_flag = irq_q;
`else
    assign irq_flag = 1'b0;
`endif

    logic             wr, rd, busy, start, restart, run, tick, tx_bit;
    logic [7:0]       tx_byte, rx_shifted;
    logic [DIV_W-1:0] div_sel;

    assign wr         = enable && !rnw;
    assign rd         = enable && rnw;
    assign busy       = (state_q == S_INIT) || (state_q == S_SETUP) || (state_q == S_SHIFT);
    assign restart    = wr && (addr == ADDR_INIT);
    assign start      = wr && !busy && ((addr == ADDR_DATA) || (addr == ADDR_FF) || (addr == ADDR_00));
    assign tx_byte    = (addr == ADDR_FF) ? 8'hFF : (addr == ADDR_00) ? 8'h00 : din;
    assign run        = (state_q == S_INIT) || (state_q == S_SHIFT);
    assign div_sel    = (state_q == S_INIT) ? INIT_DIV_V : div_q;
    assign tx_bit     = lsb_q ? tx_sh_q[0] : tx_sh_q[7];
    assign rx_shifted = lsb_q ? {miso, rx_sh_q[7:1]} : {rx_sh_q[6:0], miso};

    spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .clr   (!run || restart),
        .en    (run),
        .div   (div_sel),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        cs_mask_d  = cs_mask_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_d       = rx_q;
        dout_d     = dout_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
`ifdef SPI_IRQ_EN
        irq_d      = irq_q;
        irq_en_d   = irq_en_q;
`endif

        case (state_q)
            S_INIT: begin
                mosi_d = 1'b1;
                if (tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (edge_cnt_q == INIT_LAST) begin
                        state_d    = S_IDLE;
                        sclk_d     = cpol_q;
                        edge_cnt_d = '0;
                    end
                end
            end
            S_IDLE, S_DONE: begin
                sclk_d = cpol_q;
                if (start) begin
                    tx_sh_d    = tx_byte;
                    edge_cnt_d = '0;
                    state_d    = S_SETUP;
`ifdef SPI_IRQ_EN
                    if (irq_en_q) irq_d = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (!cpha_q) begin
                    mosi_d  = tx_bit;
                    tx_sh_d = shift_tx(tx_sh_q, lsb_q);
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    // Even count = leading edge; leading samples when cpha=0, trailing when cpha=1.
                    if (~edge_cnt_q[0] ^ cpha_q) begin
                        rx_sh_d = rx_shifted;
                    end else begin
                        mosi_d  = tx_bit;
                        tx_sh_d = shift_tx(tx_sh_q, lsb_q);
                    end
                    if (edge_cnt_q[3:0] == 4'hF) begin
                        state_d = S_DONE;
                        rx_d    = rx_sh_d;
                        mosi_d  = 1'b1;
                        sclk_d  = cpol_q;
`ifdef SPI_IRQ_EN
                        if (irq_en_q) irq_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr && !busy) begin
            if (addr == ADDR_CTRL) begin
                cpol_d = din[CTRL_CPOL];
                cpha_d = din[CTRL_CPHA];
                lsb_d  = din[CTRL_LSB];
`ifdef SPI_IRQ_EN
                irq_en_d = din[CTRL_IRQ_EN];
`endif
            end
            if (addr == ADDR_DIV) div_d = DIV_W'(din);
        end
        if (wr && (addr == ADDR_CS)) cs_mask_d = din[NUM_CS-1:0];
`ifdef SPI_IRQ_EN
        if (wr && (addr == ADDR_IRQCLR)) irq_d = 1'b0;
`endif
        // Restart keeps rx, control and cs_mask; a zero divider falls back to the init divider.
        if (restart) begin
            state_d    = S_INIT;
            edge_cnt_d = '0;
            sclk_d     = 1'b0;
            mosi_d     = 1'b1;
            if (div_q == '0) div_d = INIT_DIV_V;
        end
        ss_d = (state_d == S_INIT) ? '1 : ~cs_mask_d;

        if (rd) begin
            case (addr)
                ADDR_RX:     dout_d = rx_q;
                ADDR_STATUS: dout_d = {busy, irq_flag, 3'b000, lsb_q, cpha_q, cpol_q};
                default:     dout_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT;
            div_q      <= INIT_DIV_V;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            cs_mask_q  <= '0;
            ss_q       <= '1;
            tx_sh_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
            rx_q       <= 8'h00;
            dout_q     <= 8'h00;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
`ifdef SPI_IRQ_EN
            irq_q      <= 1'b0;
            irq_en_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            cs_mask_q  <= cs_mask_d;
            ss_q       <= ss_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_q       <= rx_d;
            dout_q     <= dout_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
`ifdef SPI_IRQ_EN
            irq_q      <= irq_d;
            irq_en_q   <= irq_en_d;
`endif
        end
    end

    assign dout = dout_q;
    assign mosi = mosi_q;
    assign sclk = sclk_q;
    assign ss   = ss_q;
    assign irq  = irq_flag;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: scoreboard of expected rx bytes plus sclk/mosi/ss monitors.
`timescale 1ns/1ps
module tb_spi_master_gen;
    import spi_master_pkg::*;

    localparam int NUM_CS = 2;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic              enable = 1'b0;
    logic              rnw    = 1'b1;
    logic [2:0]        addr   = 3'd0;
    logic [7:0]        din    = 8'h00;
    logic [7:0]        dout;
    logic              miso, mosi, sclk, irq;
    logic [NUM_CS-1:0] ss;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         rise_cyc[$];
    logic [7:0] mosi_cap = 8'h00;
    int         sclk_edges = 0;
    logic       mon_on = 1'b0;
    int         mon_bad = 0;

    logic       slv_loop = 1'b1;
    logic       slv_cpha = 1'b0;
    logic       slv_lsb  = 1'b0;
    logic [7:0] slv_byte = 8'h00;
    int         arm_base = 0;

    spi_master_gen #(
        .NUM_CS      (NUM_CS),
        .DIV_W       (8),
        .INIT_DIV    (63),
        .INIT_CLOCKS (80)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .rnw    (rnw),
        .addr   (addr),
        .din    (din),
        .dout   (dout),
        .miso   (miso),
        .mosi   (mosi),
        .sclk   (sclk),
        .ss     (ss),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge sclk) begin
        rise_cyc.push_back(cyc);
        mosi_cap <= {mosi_cap[6:0], mosi};
    end

    always @(sclk) sclk_edges <= sclk_edges + 1;

    always @(posedge clk) begin
        if (mon_on && ((ss !== '1) || (mosi !== 1'b1))) mon_bad <= mon_bad + 1;
    end

    // Slave model: bit presented depends on how many sclk edges have passed since arming.
    function automatic logic slave_bit(input int e, input logic cpha, input logic lsb, input logic [7:0] b);
        int k;
        if (cpha) begin
            if (e < 1) return 1'b1;
            k = (e - 1) / 2;
        end else begin
            k = e / 2;
        end
        if (k > 7) return 1'b1;
        return lsb ? b[k] : b[7-k];
    endfunction

    assign miso = slv_loop ? mosi : slave_bit(sclk_edges - arm_base, slv_cpha, slv_lsb, slv_byte);

    function automatic int bad_periods(input int base, input int period);
        int bad = 0;
        for (int i = base + 1; i < rise_cyc.size(); i++) begin
            if (rise_cyc[i] - rise_cyc[i-1] != period) bad++;
        end
        return bad;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        enable = 1'b1; rnw = 1'b0; addr = a; din = d;
        @(negedge clk);
        enable = 1'b0; rnw = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        enable = 1'b1; rnw = 1'b1; addr = a;
        @(negedge clk);
        enable = 1'b0;
        d = dout;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, output int busy_cnt, output logic [7:0] last_st);
        logic [7:0] st;
        st = 8'h00;
        busy_cnt = 0;
        for (int i = 0; i < limit; i++) begin
            bus_read(ADDR_STATUS, st);
            if (!st[7]) begin
                last_st = st;
                return;
            end
            busy_cnt++;
        end
        last_st  = st;
        busy_cnt = -1;
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] v;
        logic [7:0] e;
        bus_read(ADDR_RX, v);
        if (exp_q.size() == 0) begin
            total++;
            fails++;
            $error("FAIL %s: observed 0x%0h with no expected byte queued", tag, v);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'h0, v}, {24'h0, e});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bc;
        int         base;
        logic [7:0] st;

        repeat (3) @(negedge clk);
        check("reset_ss",   {30'h0, ss},   32'h3);
        check("reset_mosi", {31'h0, mosi}, 32'h1);
        check("reset_sclk", {31'h0, sclk}, 32'h0);
        check("reset_dout", {24'h0, dout}, 32'h0);
        check("reset_irq",  {31'h0, irq},  32'h0);

        // Init burst after reset
        base   = rise_cyc.size();
        mon_on = 1'b1;
        reset  = 1'b0;
        wait_idle(12000, bc, st);
        mon_on = 1'b0;
        check("init_done",     {31'h0, bc != -1},        32'h1);
        check("init_status",   {24'h0, st},              32'h00);
        check("init_rises",    rise_cyc.size() - base,   32'd80);
        check("init_period",   bad_periods(base, 128),   32'd0);
        check("init_ss_mosi",  mon_bad,                  32'd0);
        check("init_sclk_end", {31'h0, sclk},            32'h0);

        // Mode 0, div 3, loopback
        bus_write(ADDR_CS, 8'h01);
        check("cs_write_ss", {30'h0, ss}, 32'h2);
        bus_write(ADDR_DIV, 8'd3);
        bus_write(ADDR_CTRL, 8'h00);
        slv_loop = 1'b1;
        base = rise_cyc.size();
        exp_q.push_back(8'hA5);
        bus_write(ADDR_DATA, 8'hA5);
        wait_idle(400, bc, st);
        check("m0_busy_cycles", bc,                     32'd65);
        check("m0_rises",       rise_cyc.size() - base, 32'd8);
        check("m0_period",      bad_periods(base, 8),   32'd0);
        check("m0_mosi_bits",   {24'h0, mosi_cap},      32'hA5);
        check_rx("m0_rx");
        check("m0_idle_mosi",   {31'h0, mosi},          32'h1);

        // Mode 3, LSB first, W2 against slave returning 0x3C
        bus_write(ADDR_CTRL, 8'h07);
        idle(2);
        check("m3_idle_sclk", {31'h0, sclk}, 32'h1);
        bus_read(ADDR_STATUS, st);
        check("m3_status", {24'h0, st}, 32'h07);
        slv_loop = 1'b0; slv_cpha = 1'b1; slv_lsb = 1'b1; slv_byte = 8'h3C;
        arm_base = sclk_edges;
        exp_q.push_back(8'h3C);
        bus_write(ADDR_00, 8'h55);
        idle(20);
        check("m3_mosi_zero", {31'h0, mosi}, 32'h0);
        wait_idle(400, bc, st);
        check("m3_done",      {31'h0, bc != -1}, 32'h1);
        check_rx("m3_rx");
        check("m3_end_sclk",  {31'h0, sclk}, 32'h1);
        check("m3_end_mosi",  {31'h0, mosi}, 32'h1);

        // Second W0 while busy must be ignored
        bus_write(ADDR_CTRL, 8'h00);
        idle(2);
        slv_cpha = 1'b0; slv_lsb = 1'b0; slv_byte = 8'h96;
        arm_base = sclk_edges;
        exp_q.push_back(8'h96);
        base = rise_cyc.size();
        bus_write(ADDR_DATA, 8'h11);
        idle(10);
        bus_write(ADDR_DATA, 8'h22);
        wait_idle(400, bc, st);
        check("ign_done",  {31'h0, bc != -1},       32'h1);
        check("ign_rises", rise_cyc.size() - base,  32'd8);
        check("ign_mosi",  {24'h0, mosi_cap},       32'h11);
        check_rx("ign_rx");
        idle(100);
        bus_read(ADDR_STATUS, st);
        check("ign_no_second", {24'h0, st}, 32'h00);

        // W7 aborts a transfer and reruns the init burst; rx is kept
        slv_loop = 1'b1;
        bus_write(ADDR_DATA, 8'h33);
        idle(20);
        exp_q.push_back(8'h96);
        bus_write(ADDR_INIT, 8'h00);
        check("w7_ss_high", {30'h0, ss}, 32'h3);
        base = rise_cyc.size();
        wait_idle(12000, bc, st);
        check("w7_done",     {31'h0, bc != -1},      32'h1);
        check("w7_rises",    rise_cyc.size() - base, 32'd80);
        check("w7_period",   bad_periods(base, 128), 32'd0);
        check("w7_ss_back",  {30'h0, ss},            32'h2);
        check_rx("w7_rx_kept");

`ifdef SPI_IRQ_EN
        bus_write(ADDR_CTRL, 8'h08);
        exp_q.push_back(8'hFF);
        bus_write(ADDR_FF, 8'h00);
        wait_idle(400, bc, st);
        check("irq_status", {24'h0, st},  32'h40);
        check("irq_set",    {31'h0, irq}, 32'h1);
        check_rx("irq_rx");
        exp_q.push_back(8'hFF);
        bus_write(ADDR_FF, 8'h00);
        check("irq_clr_on_start", {31'h0, irq}, 32'h0);
        wait_idle(400, bc, st);
        check("irq_set_again", {31'h0, irq}, 32'h1);
        bus_write(ADDR_IRQCLR, 8'h00);
        check("irq_w6_clear", {31'h0, irq}, 32'h0);
        check_rx("irq_rx2");
`else
        bus_write(ADDR_CTRL, 8'h08);
        exp_q.push_back(8'hFF);
        bus_write(ADDR_FF, 8'h00);
        wait_idle(400, bc, st);
        check("noirq_status", {24'h0, st},  32'h00);
        check("noirq_pin",    {31'h0, irq}, 32'h0);
        check_rx("noirq_rx");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
